// File: rtl/msg_rr_arbiter.sv
// msg_rr_arbiter
//   Shares one outgoing message channel between NREQ producers. A round-robin
//   arbiter picks one requester while idle, latches its message, checks the
//   redundancy field and forwards good messages over a 4-phase req/ack
//   handshake. Bad messages are acknowledged, dropped and counted.
//
// Ports
//   src_clk  in   1         clock, all logic on the rising edge
//   reset    in   1         synchronous active-low reset
//   i_req    in   NREQ      per-requester 4-phase request
//   i_msg    in   NREQ*MSZ  requester k message at [k*MSZ +: MSZ]
//   i_ack    out  NREQ      per-requester acknowledge
//   o_req    out  1         output 4-phase request
//   o_msg    out  MSZ       latched message {src, dst, dat, red}, red at LSBs
//   o_ack    in   1         output acknowledge
//   o_gnt    out  NREQ      one-hot of the last granted requester
//   o_busy   out  1         high whenever the FSM is not idle
//   err_cnt  out  4         dropped bad-redundancy messages, saturating at 15

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module msg_rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned ASZ  = `NS_ADDRESS_SIZE,
    parameter int unsigned DSZ  = `NS_DATA_SIZE,
    parameter int unsigned RSZ  = `NS_REDUN_SIZE,
    parameter int unsigned MSZ  = 2 * ASZ + DSZ + RSZ
) (
    input  logic                src_clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     i_req,
    input  logic [NREQ*MSZ-1:0] i_msg,
    output logic [NREQ-1:0]     i_ack,
    output logic                o_req,
    output logic [MSZ-1:0]      o_msg,
    input  logic                o_ack,
    output logic [NREQ-1:0]     o_gnt,
    output logic                o_busy,
    output logic [3:0]          err_cnt
);

    localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BSZ = MSZ - RSZ;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StRelease
    } state_e;

    state_e        state;
    logic [PW-1:0] ptr;

    // Redundancy is the XOR of all RSZ-wide chunks of {src, dst, dat}; the
    // top chunk is zero-padded when the body is not a multiple of RSZ.
    function automatic logic [RSZ-1:0] calc_redun(input logic [BSZ-1:0] body);
        logic [RSZ-1:0] r;
        r = '0;
        for (int unsigned c = 0; c < BSZ; c += RSZ) begin
            r = r ^ RSZ'(body >> c);
        end
        return r;
    endfunction

    logic [NREQ-1:0] eligible;
    logic            found;
    logic [PW-1:0]   win;
    logic [PW-1:0]   ptr_next;
    logic [MSZ-1:0]  win_msg;
    logic            win_ok;
    logic [NREQ-1:0] win_onehot;
    int unsigned     scan_idx;

    // Round-robin pick: scan ptr, ptr+1, ... wrapping at NREQ; first hit wins.
    // A requester still holding its acknowledge is not eligible again.
    always_comb begin
        eligible = i_req & ~i_ack;
        found    = 1'b0;
        win      = '0;
        scan_idx = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            scan_idx = 32'(ptr) + off;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!found && eligible[PW'(scan_idx)]) begin
                found = 1'b1;
                win   = PW'(scan_idx);
            end
        end
        win_msg    = i_msg[win * MSZ +: MSZ];
        win_ok     = (calc_redun(win_msg[MSZ-1:RSZ]) == win_msg[RSZ-1:0]);
        win_onehot = NREQ'(1) << win;
        ptr_next   = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end

    assign o_busy = (state != StIdle);

    always_ff @(posedge src_clk) begin
        if (!reset) begin
            state   <= StIdle;
            ptr     <= '0;
            i_ack   <= '0;
            o_req   <= 1'b0;
            o_msg   <= '0;
            o_gnt   <= '0;
            err_cnt <= '0;
        end else begin
            // Acknowledges drop as soon as their request is withdrawn,
            // whatever the FSM is doing.
            i_ack <= i_ack & i_req;
            unique case (state)
                StIdle: begin
                    if (found) begin
                        i_ack <= (i_ack & i_req) | win_onehot;
                        o_gnt <= win_onehot;
                        ptr   <= ptr_next;
                        o_msg <= win_msg;
                        if (win_ok) begin
                            o_req <= 1'b1;
                            state <= StSend;
                        end else if (err_cnt != 4'hF) begin
                            err_cnt <= err_cnt + 4'd1;
                        end
                    end
                end
                StSend: begin
                    if (o_ack) begin
                        o_req <= 1'b0;
                        state <= StRelease;
                    end
                end
                StRelease: begin
                    if (!o_ack) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
